operand_fetch: RTL and testbench

//   Read side of the register files: the counterpart of the writeback-data path.

---
 rtl/operand_fetch_if.sv | 70 +++++++
 rtl/operand_fetch.sv | 134 +++++++++++++
 tb/tb_operand_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Bus bundle between decode, the register files, writeback and execute for operand_fetch.
// Signal groups:
//   decode side : in_valid/in_ready handshake plus the in_rs/in_rt/in_rd descriptor fields
//   file reads  : rf_int_a/b and rf_flt_a/b addresses, rf_*_qa/qb asynchronous read data
//   writeback   : wb_we, wb_addr, wb_float, wb_data
//   execute side: out_valid/out_ready handshake, out_a/out_b operands, destination passthrough
//   status      : busy_count
// Modports:
//   slave  - the operand fetch stage itself
//   master - the surrounding pipeline (decode, register files, writeback, execute)
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     in_rs;
  logic [AW-1:0]     in_rt;
  logic              in_rs_float;
  logic              in_rt_float;
  logic [AW-1:0]     in_rd;
  logic              in_rd_float;
  logic              in_rd_we;

  logic [AW-1:0]     rf_int_a;
  logic [AW-1:0]     rf_int_b;
  logic [DATA_W-1:0] rf_int_qa;
  logic [DATA_W-1:0] rf_int_qb;
  logic [AW-1:0]     rf_flt_a;
  logic [AW-1:0]     rf_flt_b;
  logic [DATA_W-1:0] rf_flt_qa;
  logic [DATA_W-1:0] rf_flt_qb;

  logic              wb_we;
  logic [AW-1:0]     wb_addr;
  logic              wb_float;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [AW-1:0]     out_rd;
  logic              out_rd_float;
  logic              out_rd_we;

  logic [AW:0]       busy_count;

  modport slave (
    input  in_valid, in_rs, in_rt, in_rs_float, in_rt_float, in_rd, in_rd_float, in_rd_we,
    output in_ready,
    output rf_int_a, rf_int_b, rf_flt_a, rf_flt_b,
    input  rf_int_qa, rf_int_qb, rf_flt_qa, rf_flt_qb,
    input  wb_we, wb_addr, wb_float, wb_data,
    output out_valid, out_a, out_b, out_rd, out_rd_float, out_rd_we,
    input  out_ready,
    output busy_count
  );

  modport master (
    output in_valid, in_rs, in_rt, in_rs_float, in_rt_float, in_rd, in_rd_float, in_rd_we,
    input  in_ready,
    input  rf_int_a, rf_int_b, rf_flt_a, rf_flt_b,
    output rf_int_qa, rf_int_qb, rf_flt_qa, rf_flt_qb,
    output wb_we, wb_addr, wb_float, wb_data,
    input  out_valid, out_a, out_b, out_rd, out_rd_float, out_rd_we,
    output out_ready,
    input  busy_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source operands from the integer or float register
// file, forwards same-cycle writeback data, tracks pending destinations in a
// scoreboard and hands registered operands to execute over valid/ready.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - operand_fetch_if.slave: decode handshake, file read ports, writeback,
//           execute handshake and busy_count (popcount of the scoreboard, saturating
//           at 2**AW)
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fetch_if.slave bus
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0]   busy_int_reg, busy_int_next;
  logic [NREG-1:0]   busy_flt_reg, busy_flt_next;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_a_reg, out_b_reg;
  logic [AW-1:0]     out_rd_reg;
  logic              out_rd_float_reg, out_rd_we_reg;

  // Writebacks to integer r0 are dropped everywhere: no forwarding, no clear.
  logic wb_en;
  logic wb_hit_rs, wb_hit_rt, wb_hit_rd;
  logic rs_zero, rt_zero, rd_writes;
  logic rs_busy, rt_busy, rd_busy;
  logic hazard, in_ready, accept, set_en;
  logic [DATA_W-1:0] op_a, op_b;

  assign bus.rf_int_a = bus.in_rs;
  assign bus.rf_int_b = bus.in_rt;
  assign bus.rf_flt_a = bus.in_rs;
  assign bus.rf_flt_b = bus.in_rt;

  assign wb_en = bus.wb_we & (bus.wb_float | (bus.wb_addr != '0));

  assign wb_hit_rs = wb_en & (bus.wb_addr == bus.in_rs) & (bus.wb_float == bus.in_rs_float);
  assign wb_hit_rt = wb_en & (bus.wb_addr == bus.in_rt) & (bus.wb_float == bus.in_rt_float);
  assign wb_hit_rd = wb_en & (bus.wb_addr == bus.in_rd) & (bus.wb_float == bus.in_rd_float);

  assign rs_zero   = ~bus.in_rs_float & (bus.in_rs == '0);
  assign rt_zero   = ~bus.in_rt_float & (bus.in_rt == '0);
  assign rd_writes = bus.in_rd_we & (bus.in_rd_float | (bus.in_rd != '0));

  assign rs_busy = bus.in_rs_float ? busy_flt_reg[bus.in_rs] : busy_int_reg[bus.in_rs];
  assign rt_busy = bus.in_rt_float ? busy_flt_reg[bus.in_rt] : busy_int_reg[bus.in_rt];
  assign rd_busy = bus.in_rd_float ? busy_flt_reg[bus.in_rd] : busy_int_reg[bus.in_rd];

  // A busy register whose writeback lands this cycle is no longer a hazard:
  // sources take the forwarded data, and the destination bit is re-set below.
  assign hazard = (rs_busy & ~wb_hit_rs) | (rt_busy & ~wb_hit_rt) |
                  (rd_writes & rd_busy & ~wb_hit_rd);

  assign in_ready = (~out_valid_reg | bus.out_ready) & ~hazard;
  assign accept   = bus.in_valid & in_ready;
  assign set_en   = accept & rd_writes;

  assign bus.in_ready = in_ready;

  always_comb begin
    op_a = bus.in_rs_float ? bus.rf_flt_qa : bus.rf_int_qa;
    if (wb_hit_rs) op_a = bus.wb_data;
    if (rs_zero)   op_a = '0;
    op_b = bus.in_rt_float ? bus.rf_flt_qb : bus.rf_int_qb;
    if (wb_hit_rt) op_b = bus.wb_data;
    if (rt_zero)   op_b = '0;
  end

  // Per-register scoreboard update; a set from an accepted instruction overrides
  // a clear from a writeback landing on the same bit in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      logic set_int, set_flt, clr_int, clr_flt;
      assign set_int = set_en & ~bus.in_rd_float & (bus.in_rd == AW'(gi));
      assign set_flt = set_en &  bus.in_rd_float & (bus.in_rd == AW'(gi));
      assign clr_int = wb_en & ~bus.wb_float & (bus.wb_addr == AW'(gi));
      assign clr_flt = wb_en &  bus.wb_float & (bus.wb_addr == AW'(gi));
      assign busy_int_next[gi] = set_int | (busy_int_reg[gi] & ~clr_int);
      assign busy_flt_next[gi] = set_flt | (busy_flt_reg[gi] & ~clr_flt);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_int_reg     <= '0;
      busy_flt_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_a_reg        <= '0;
      out_b_reg        <= '0;
      out_rd_reg       <= '0;
      out_rd_float_reg <= 1'b0;
      out_rd_we_reg    <= 1'b0;
    end else begin
      busy_int_reg <= busy_int_next;
      busy_flt_reg <= busy_flt_next;
      if (accept) begin
        out_valid_reg    <= 1'b1;
        out_a_reg        <= op_a;
        out_b_reg        <= op_b;
        out_rd_reg       <= bus.in_rd;
        out_rd_float_reg <= bus.in_rd_float;
        out_rd_we_reg    <= bus.in_rd_we;
      end else if (bus.out_ready) begin
        out_valid_reg    <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_reg;
  assign bus.out_a        = out_a_reg;
  assign bus.out_b        = out_b_reg;
  assign bus.out_rd       = out_rd_reg;
  assign bus.out_rd_float = out_rd_float_reg;
  assign bus.out_rd_we    = out_rd_we_reg;

  // Popcount of both files; combinational so reset zeroes it immediately.
  logic [AW+1:0] pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < NREG; i++) begin
      pop = pop + (AW+2)'(busy_int_reg[i]) + (AW+2)'(busy_flt_reg[i]);
    end
  end

  assign bus.busy_count = (pop > (AW+2)'(NREG)) ? (AW+1)'(NREG) : pop[AW:0];

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  localparam int DATA_W = 32;
  localparam int AW     = 5;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [DATA_W-1:0] int_rf [32];
  logic [DATA_W-1:0] flt_rf [32];

  operand_fetch_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  operand_fetch #(.DATA_W(DATA_W), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read register file models.
  assign bus.rf_int_qa = int_rf[bus.rf_int_a];
  assign bus.rf_int_qb = int_rf[bus.rf_int_b];
  assign bus.rf_flt_qa = flt_rf[bus.rf_flt_a];
  assign bus.rf_flt_qb = flt_rf[bus.rf_flt_b];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic rs_f, input logic [4:0] rt,
                       input logic rt_f, input logic [4:0] rd, input logic rd_f,
                       input logic we);
    bus.in_valid    = 1'b1;
    bus.in_rs       = rs;
    bus.in_rs_float = rs_f;
    bus.in_rt       = rt;
    bus.in_rt_float = rt_f;
    bus.in_rd       = rd;
    bus.in_rd_float = rd_f;
    bus.in_rd_we    = we;
  endtask

  task automatic writeback(input logic [4:0] addr, input logic fl, input logic [31:0] data);
    bus.wb_we    = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_float = fl;
    bus.wb_data  = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0 || bus.out_rd !== 5'd0 ||
        bus.out_rd_we !== 1'b0 || bus.out_rd_float !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got a=%h b=%h rd=%0d we=%b fl=%b want all 0",
                         bus.out_a, bus.out_b, bus.out_rd, bus.out_rd_we, bus.out_rd_float);
    end
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL reset_busy_count: got %0d want 0", bus.busy_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    $display("reset: out_valid=%b busy_count=%0d", bus.out_valid, bus.busy_count);
  endtask

  task automatic test_r0();
    issue(5'd0, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h0 || bus.out_b !== 32'h1000_0002) begin
      errors++; $display("FAIL r0_read: got v=%b a=%h b=%h want v=1 a=00000000 b=10000002",
                         bus.out_valid, bus.out_a, bus.out_b);
    end
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL r0_no_busy: got %0d want 0", bus.busy_count);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL r0_drain: got out_valid=%b want 0", bus.out_valid);
    end
    $display("r0: out_a=%h busy_count=%0d", bus.out_a, bus.busy_count);
  endtask

  task automatic test_forward();
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL fwd_busy_set: got %0d want 1", bus.busy_count);
    end
    issue(5'd3, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    writeback(5'd3, 1'b0, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL fwd_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.wb_we    = 1'b0;
    checks++;
    if (bus.out_a !== 32'hDEAD_BEEF || bus.out_b !== 32'hF000_0004) begin
      errors++; $display("FAIL fwd_data: got a=%h b=%h want a=deadbeef b=f0000004",
                         bus.out_a, bus.out_b);
    end
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL fwd_busy_clear: got %0d want 0", bus.busy_count);
    end
    tick();
    $display("forward: out_a=%h busy_count=%0d", bus.out_a, bus.busy_count);
  endtask

  task automatic test_raw();
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1);
    tick();
    issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_float_no_stall: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_a !== 32'hF000_0005) begin
      errors++; $display("FAIL raw_float_data: got %h want f0000005", bus.out_a);
    end
    issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL raw_stall_hold: got in_ready=%b out_valid=%b want 0 0",
                         bus.in_ready, bus.out_valid);
    end
    writeback(5'd5, 1'b0, 32'hCAFE_0005);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_release: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.wb_we    = 1'b0;
    checks++;
    if (bus.out_a !== 32'hCAFE_0005 || bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL raw_result: got a=%h busy=%0d want a=cafe0005 busy=0",
                         bus.out_a, bus.busy_count);
    end
    tick();
    $display("raw: out_a=%h busy_count=%0d", bus.out_a, bus.busy_count);
  endtask

  task automatic test_waw();
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1);
    tick();
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL waw_stall: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    writeback(5'd7, 1'b0, 32'h7777_7777);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL waw_release: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.wb_we    = 1'b0;
    checks++;
    if (bus.busy_count !== 6'd1 || bus.out_rd !== 5'd7 || bus.out_rd_we !== 1'b1) begin
      errors++; $display("FAIL waw_set_wins: got busy=%0d rd=%0d we=%b want busy=1 rd=7 we=1",
                         bus.busy_count, bus.out_rd, bus.out_rd_we);
    end
    writeback(5'd7, 1'b0, 32'h7777_7777);
    tick();
    bus.wb_we = 1'b0;
    checks++;
    if (bus.busy_count !== 6'd0) begin
      errors++; $display("FAIL waw_clear: got %0d want 0", bus.busy_count);
    end
    $display("waw: busy_count=%0d", bus.busy_count);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    issue(5'd8, 1'b0, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    issue(5'd11, 1'b0, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_a !== 32'h1000_0008 ||
          bus.out_b !== 32'h1000_0009 || bus.out_rd !== 5'd10 || bus.out_rd_float !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b a=%h b=%h rd=%0d fl=%b want 0 1 10000008 10000009 10 1",
                           i, bus.in_ready, bus.out_valid, bus.out_a, bus.out_b,
                           bus.out_rd, bus.out_rd_float);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready: got %b want 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_a !== 32'h1000_000B) begin
      errors++; $display("FAIL bp_b2b_1: got %h want 1000000b", bus.out_a);
    end
    issue(5'd12, 1'b0, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h1000_000C) begin
      errors++; $display("FAIL bp_b2b_2: got v=%b a=%h want v=1 a=1000000c",
                         bus.out_valid, bus.out_a);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid);
    end
    $display("backpressure: out_valid=%b", bus.out_valid);
  endtask

  task automatic test_saturate();
    for (int r = 1; r < 32; r++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (bus.busy_count !== 6'd31) begin
      errors++; $display("FAIL sat_int_all: got %0d want 31", bus.busy_count);
    end
    for (int r = 0; r < 2; r++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy_count !== 6'd32) begin
      errors++; $display("FAIL sat_limit: got %0d want 32", bus.busy_count);
    end
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    $display("saturate: busy_count=%0d", bus.busy_count);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    issue(5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy_count !== 6'd1) begin
      errors++; $display("FAIL mid_setup: got v=%b busy=%0d want 1 1", bus.out_valid, bus.busy_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy_count !== 6'd0 || bus.out_a !== 32'h0) begin
      errors++; $display("FAIL mid_async_reset: got v=%b busy=%0d a=%h want 0 0 0",
                         bus.out_valid, bus.busy_count, bus.out_a);
    end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    writeback(5'd9, 1'b0, 32'h9999_9999);
    tick();
    bus.wb_we = 1'b0;
    checks++;
    if (bus.busy_count !== 6'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_post_wb: got busy=%0d v=%b want 0 0", bus.busy_count, bus.out_valid);
    end
    $display("reset_mid: busy_count=%0d", bus.busy_count);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) begin
      int_rf[i] = 32'h1000_0000 + 32'(i);
      flt_rf[i] = 32'hF000_0000 + 32'(i);
    end
    int_rf[0] = 32'h0000_1234;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_rs       = '0;
    bus.in_rt       = '0;
    bus.in_rs_float = 1'b0;
    bus.in_rt_float = 1'b0;
    bus.in_rd       = '0;
    bus.in_rd_float = 1'b0;
    bus.in_rd_we    = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_float    = 1'b0;
    bus.wb_data     = '0;
    bus.out_ready   = 1'b1;

    test_reset();
    test_r0();
    test_forward();
    test_raw();
    test_waw();
    test_backpressure();
    test_saturate();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
